rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares the single combinational read port of the byte-addressed boot ROM
//  (base 0xBFC00000) between instruction fetch (F) and data load (L).
//  Arbitrates requests, drives the ROM address, registers the 32-bit word and
//  returns it with a valid/ready handshake. Flags misaligned and out-of-range
//  accesses instead of indexing outside the ROM.
// PARAMETERS
//  ADDR_W        32            address width
//  DATA_W        32            returned word width
//  BASE          32'hBFC00000  first byte address of ROM
//  SIZE          4096          ROM size in bytes (power of 2, >=4)
//  STARVE_LIMIT  3             consecutive F losses before F is forced to win (>=1)
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       asynchronous reset, active-high
//  f_valid_i    in   1       fetch request valid
//  f_addr_i     in   ADDR_W  fetch byte address
//  f_ready_o    out  1       fetch request accepted this cycle
//  l_valid_i    in   1       load request valid
//  l_addr_i     in   ADDR_W  load byte address
//  l_ready_o    out  1       load request accepted this cycle
//  f_rvalid_o   out  1       response for fetch valid
//  f_rready_i   in   1       fetch consumes response
//  l_rvalid_o   out  1       response for load valid
//  l_rready_i   in   1       load consumes response
//  rdata_o      out  DATA_W  response word (shared by both ports)
//  rerr_o       out  1       response is an error (rdata_o = 0)
//  rom_addr_o   out  ADDR_W  byte address to ROM a_i
//  rom_data_i   in   DATA_W  ROM rd_o (combinational, little-endian word)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; f/l_ready_o=0, f/l_rvalid_o=0,
//   rdata_o=0, rerr_o=0, rom_addr_o=BASE, starve counter=0. In-flight request dropped.
//  FSM IDLE -> READ -> RESP -> IDLE (error path IDLE -> RESP).
//  IDLE: ready outputs combinational from valids; at most one asserted.
//   Winner: L if l_valid_i, except F wins when f_valid_i and starve count
//   == STARVE_LIMIT; F if only f_valid_i. Accept = valid & ready.
//   On accept: latch addr and port id; starve counter: +1 (saturating) when F
//   valid but L accepted, cleared when F accepted, unchanged otherwise.
//   Error if addr[1:0]!=0 or addr<BASE or addr>BASE+SIZE-4 (compare in ADDR_W+1
//   bits, no wrap). Error -> RESP with rdata=0, rerr=1; else -> READ.
//  READ (1 cycle): rom_addr_o = latched addr; rom_data_i registered into
//   rdata_o at cycle end; rerr_o=0; -> RESP.
//  RESP: rvalid of latched port =1, other 0; rdata_o/rerr_o stable until
//   handshake. Handshake (rvalid & rready) -> IDLE next cycle; rready ignored
//   for the non-owning port. No ready asserted outside IDLE.
//  Latency: accept at cycle N -> rvalid at N+2 (error: N+1). Min issue interval
//   3 cycles (2 for errors). rom_addr_o holds last valid address otherwise.
//  Valids may drop without acceptance; no state changes for unaccepted requests.
// TESTING
//  F only, addr 0xBFC00000, ROM word 0x00500093: f_ready_o=1 cyc0, f_rvalid_o=1
//   cyc2, rdata_o=0x00500093, rerr_o=0; rready=1 -> IDLE cyc3.
//  F and L valid same cycle, distinct addrs: L accepted first, F accepted in the
//   next IDLE; each response on own rvalid with correct word.
//  F and L held valid continuously, STARVE_LIMIT=3: grant order L,L,L,F,L,L,L,F.
//  Addr 0xBFC00002, 0xBFC01000, 0xBFBFFFFC -> rerr_o=1, rdata_o=0, rvalid at
//   accept+1; 0xBFC00FFC -> rerr_o=0, last ROM word.
//  L response with l_rready_i low 5 cycles: l_rvalid_o, rdata_o stable, no
//   ready asserted; release -> IDLE next cycle.
//  rst_i pulsed mid-READ (async, between edges): all outputs 0 immediately,
//   rom_addr_o=BASE; next F request served with normal N+2 latency.

Source files
------------

// File: rtl/rom_port_arbiter_if.sv
// Request/response and ROM-side bus of the boot-ROM port arbiter.
// The arbiter connects through the slave modport; requesters and the ROM use master.
interface rom_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              f_valid_i;
    logic [ADDR_W-1:0] f_addr_i;
    logic              f_ready_o;
    logic              l_valid_i;
    logic [ADDR_W-1:0] l_addr_i;
    logic              l_ready_o;
    logic              f_rvalid_o;
    logic              f_rready_i;
    logic              l_rvalid_o;
    logic              l_rready_i;
    logic [DATA_W-1:0] rdata_o;
    logic              rerr_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_data_i;

    modport slave (
        input  f_valid_i, f_addr_i, l_valid_i, l_addr_i,
        input  f_rready_i, l_rready_i, rom_data_i,
        output f_ready_o, l_ready_o, f_rvalid_o, l_rvalid_o,
        output rdata_o, rerr_o, rom_addr_o
    );

    modport master (
        output f_valid_i, f_addr_i, l_valid_i, l_addr_i,
        output f_rready_i, l_rready_i, rom_data_i,
        input  f_ready_o, l_ready_o, f_rvalid_o, l_rvalid_o,
        input  rdata_o, rerr_o, rom_addr_o
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares the boot ROM's single combinational read port between fetch (F) and load (L),
// with starvation protection for F and error responses for misaligned/out-of-range addresses.
module rom_port_arbiter #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W-1:0] BASE         = ADDR_W'(32'hBFC00000),
    parameter int                SIZE         = 4096,
    parameter int                STARVE_LIMIT = 3
) (
    input logic               clk_i,
    input logic               rst_i,
    rom_port_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);
    // Range bounds carry one extra bit so BASE+SIZE-4 cannot wrap.
    localparam logic [ADDR_W:0]   LO    = {1'b0, BASE};
    localparam logic [ADDR_W:0]   HI    = {1'b0, BASE} + (ADDR_W + 1)'(SIZE - 4);

    logic [1:0]        state;
    logic [CNT_W-1:0]  starve;
    logic              owner_l;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rdata;
    logic              rerr;

    logic              idle;
    logic              f_force;
    logic              f_grant;
    logic              l_grant;
    logic              accept;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W:0]   addr_ext;
    logic              addr_err;
    logic              resp_done;

    always_comb begin
        idle      = (state == S_IDLE) && !rst_i;
        f_force   = bus.f_valid_i && (starve == LIMIT);
        l_grant   = idle && bus.l_valid_i && !f_force;
        f_grant   = idle && bus.f_valid_i && (f_force || !bus.l_valid_i);
        accept    = l_grant || f_grant;
        req_addr  = l_grant ? bus.l_addr_i : bus.f_addr_i;
        addr_ext  = {1'b0, req_addr};
        addr_err  = (req_addr[1:0] != 2'b00) || (addr_ext < LO) || (addr_ext > HI);
        resp_done = (state == S_RESP) && (owner_l ? bus.l_rready_i : bus.f_rready_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            starve   <= '0;
            owner_l  <= 1'b0;
            rom_addr <= BASE;
            rdata    <= '0;
            rerr     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner_l <= l_grant;
                        if (f_grant)
                            starve <= '0;
                        else if (bus.f_valid_i && (starve != LIMIT))
                            starve <= starve + 1'b1;
                        if (addr_err) begin
                            rdata <= '0;
                            rerr  <= 1'b1;
                            state <= S_RESP;
                        end else begin
                            rom_addr <= req_addr;
                            state    <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    rdata <= bus.rom_data_i;
                    rerr  <= 1'b0;
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (resp_done)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.f_ready_o  = f_grant;
    assign bus.l_ready_o  = l_grant;
    assign bus.f_rvalid_o = (state == S_RESP) && !owner_l;
    assign bus.l_rvalid_o = (state == S_RESP) && owner_l;
    assign bus.rdata_o    = rdata;
    assign bus.rerr_o     = rerr;
    assign bus.rom_addr_o = rom_addr;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: vector table of single transactions plus
// arbitration, back-pressure and async-reset sequences against a small ROM model.
module tb_rom_port_arbiter;
    localparam logic [31:0] BASE = 32'hBFC00000;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    rom_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    rom_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .BASE        (BASE),
        .SIZE        (4096),
        .STARVE_LIMIT(3)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input int unsigned idx);
        logic [15:0] i16;
        i16 = 16'(idx);
        if (idx == 0) return 32'h00500093;
        return {i16 ^ 16'hA5A5, ~i16};
    endfunction

    function automatic logic [31:0] rom_lookup(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return rom_word(int'(off[11:2]));
    endfunction

    assign bus.rom_data_i = rom_lookup(bus.rom_addr_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request on one port, rready asserted as soon as the response appears.
    task automatic txn(input string id, input logic is_l, input logic [31:0] addr,
                       input logic exp_err, input logic [31:0] exp_data);
        if (is_l) begin bus.l_valid_i = 1'b1; bus.l_addr_i = addr; end
        else      begin bus.f_valid_i = 1'b1; bus.f_addr_i = addr; end
        #1;
        check({id, " own ready"},   is_l ? bus.l_ready_o : bus.f_ready_o, 1);
        check({id, " other ready"}, is_l ? bus.f_ready_o : bus.l_ready_o, 0);
        @(posedge clk); #1;
        bus.f_valid_i = 1'b0;
        bus.l_valid_i = 1'b0;
        if (!exp_err) begin
            check({id, " rvalid early"}, is_l ? bus.l_rvalid_o : bus.f_rvalid_o, 0);
            check({id, " rom_addr"}, bus.rom_addr_o, addr);
            @(posedge clk); #1;
        end
        check({id, " own rvalid"},   is_l ? bus.l_rvalid_o : bus.f_rvalid_o, 1);
        check({id, " other rvalid"}, is_l ? bus.f_rvalid_o : bus.l_rvalid_o, 0);
        check({id, " rdata"}, bus.rdata_o, exp_data);
        check({id, " rerr"},  bus.rerr_o, exp_err);
        if (is_l) bus.l_rready_i = 1'b1; else bus.f_rready_i = 1'b1;
        @(posedge clk); #1;
        bus.l_rready_i = 1'b0;
        bus.f_rready_i = 1'b0;
        check({id, " rvalid after hs"}, is_l ? bus.l_rvalid_o : bus.f_rvalid_o, 0);
    endtask

    typedef struct {
        logic        is_l;
        logic [31:0] addr;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[9];
    logic got_l[8];
    logic exp_l[8];
    logic [31:0] hold;
    int n;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 32'hBFC00000, 1'b0, 32'h00500093};
        vecs[1] = '{1'b1, 32'hBFC00004, 1'b0, rom_word(1)};
        vecs[2] = '{1'b0, 32'hBFC00002, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 32'hBFC01000, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 32'hBFBFFFFC, 1'b1, 32'h0};
        vecs[5] = '{1'b1, 32'hBFC00FFC, 1'b0, rom_word(1023)};
        vecs[6] = '{1'b0, 32'hBFC00FFC, 1'b0, rom_word(1023)};
        vecs[7] = '{1'b1, 32'hFFFFFFFC, 1'b1, 32'h0};
        vecs[8] = '{1'b0, 32'hBFC00001, 1'b1, 32'h0};
        exp_l = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        bus.f_valid_i = 1'b1; bus.f_addr_i = BASE;
        bus.l_valid_i = 1'b0; bus.l_addr_i = '0;
        bus.f_rready_i = 1'b0; bus.l_rready_i = 1'b0;
        #2;
        check("reset f_ready", bus.f_ready_o, 0);
        check("reset f_rvalid", bus.f_rvalid_o, 0);
        check("reset l_rvalid", bus.l_rvalid_o, 0);
        check("reset rdata", bus.rdata_o, 0);
        check("reset rerr", bus.rerr_o, 0);
        check("reset rom_addr", bus.rom_addr_o, BASE);
        bus.f_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++)
            txn($sformatf("v%0d", i), vecs[i].is_l, vecs[i].addr, vecs[i].exp_err, vecs[i].exp_data);

        // Simultaneous requests: L first, F in the following IDLE.
        bus.f_valid_i = 1'b1; bus.f_addr_i = 32'hBFC00010;
        bus.l_valid_i = 1'b1; bus.l_addr_i = 32'hBFC00020;
        #1;
        check("both l_ready", bus.l_ready_o, 1);
        check("both f_ready", bus.f_ready_o, 0);
        @(posedge clk); #1;
        bus.l_valid_i = 1'b0;
        check("both read f_ready", bus.f_ready_o, 0);
        @(posedge clk); #1;
        check("both l_rvalid", bus.l_rvalid_o, 1);
        check("both f_rvalid", bus.f_rvalid_o, 0);
        check("both l rdata", bus.rdata_o, rom_word(8));
        bus.l_rready_i = 1'b1;
        @(posedge clk); #1;
        bus.l_rready_i = 1'b0;
        check("both f_ready later", bus.f_ready_o, 1);
        @(posedge clk); #1;
        bus.f_valid_i = 1'b0;
        @(posedge clk); #1;
        check("both f_rvalid later", bus.f_rvalid_o, 1);
        check("both f rdata", bus.rdata_o, rom_word(4));
        bus.f_rready_i = 1'b1;
        @(posedge clk); #1;
        bus.f_rready_i = 1'b0;

        // Continuous contention: starvation limit forces every fourth grant to F.
        bus.f_valid_i = 1'b1; bus.f_addr_i = 32'hBFC00100;
        bus.l_valid_i = 1'b1; bus.l_addr_i = 32'hBFC00200;
        bus.f_rready_i = 1'b1; bus.l_rready_i = 1'b1;
        n = 0;
        #1;
        for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
            if (bus.f_ready_o && bus.l_ready_o) check("starve both ready", 1, 0);
            if (bus.f_ready_o || bus.l_ready_o) begin
                got_l[n] = bus.l_ready_o;
                n++;
            end
            @(posedge clk); #2;
        end
        bus.f_valid_i = 1'b0; bus.l_valid_i = 1'b0;
        check("starve grant count", n, 8);
        for (int k = 0; k < 8; k++)
            if (k < n) check($sformatf("starve grant%0d is_l", k), got_l[k], exp_l[k]);
        repeat (3) @(posedge clk);
        #1;
        bus.f_rready_i = 1'b0; bus.l_rready_i = 1'b0;
        check("starve drained f", bus.f_rvalid_o, 0);
        check("starve drained l", bus.l_rvalid_o, 0);

        // L response held under back-pressure while F waits and F's rready is ignored.
        bus.l_valid_i = 1'b1; bus.l_addr_i = 32'hBFC00040;
        @(posedge clk); #1;
        bus.l_valid_i = 1'b0;
        @(posedge clk); #1;
        bus.f_valid_i = 1'b1; bus.f_addr_i = 32'hBFC00044; bus.f_rready_i = 1'b1;
        hold = rom_word(16);
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp%0d l_rvalid", k), bus.l_rvalid_o, 1);
            check($sformatf("bp%0d rdata", k), bus.rdata_o, hold);
            check($sformatf("bp%0d f_ready", k), bus.f_ready_o, 0);
            check($sformatf("bp%0d l_ready", k), bus.l_ready_o, 0);
            check($sformatf("bp%0d f_rvalid", k), bus.f_rvalid_o, 0);
            @(posedge clk);
        end
        #1;
        bus.l_rready_i = 1'b1; bus.f_rready_i = 1'b0;
        @(posedge clk); #1;
        bus.l_rready_i = 1'b0;
        #1;
        check("bp release l_rvalid", bus.l_rvalid_o, 0);
        check("bp release f_ready", bus.f_ready_o, 1);
        bus.f_valid_i = 1'b0;
        #1;
        check("bp drop f_ready", bus.f_ready_o, 0);
        @(posedge clk); #1;
        check("bp drop f_rvalid", bus.f_rvalid_o, 0);
        check("bp drop rom_addr", bus.rom_addr_o, 32'hBFC00040);

        // Async reset between edges while a READ is in flight.
        bus.f_valid_i = 1'b1; bus.f_addr_i = 32'hBFC00008;
        @(posedge clk); #1;
        bus.f_valid_i = 1'b0;
        check("rst pre rom_addr", bus.rom_addr_o, 32'hBFC00008);
        #2;
        rst = 1'b1;
        #1;
        check("rst mid f_rvalid", bus.f_rvalid_o, 0);
        check("rst mid l_rvalid", bus.l_rvalid_o, 0);
        check("rst mid rdata", bus.rdata_o, 0);
        check("rst mid rerr", bus.rerr_o, 0);
        check("rst mid rom_addr", bus.rom_addr_o, BASE);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst dropped f_rvalid", bus.f_rvalid_o, 0);
        @(posedge clk); #1;
        check("rst dropped f_rvalid 2", bus.f_rvalid_o, 0);
        txn("post_rst", 1'b0, 32'hBFC00008, 1'b0, rom_word(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
